// File: rtl/rv32i_icache.sv
// rv32i_icache: direct-mapped read-only instruction cache with combinational hits and word-by-word line refill.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module rv32i_icache #(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_valid,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic                  cpu_ready,
   output logic [31:0]           cpu_rdata,
   input  logic                  flush,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [31:0]           mem_resp_data
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses
`endif
);
   localparam int WW = $clog2(WORDS_PER_LINE);
   localparam int IW = $clog2(NUM_LINES);
   localparam int OW = WW + 2;
   localparam int TW = ADDR_WIDTH - OW - IW;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t                  state;
   logic [NUM_LINES-1:0]    valid;
   logic [TW-1:0]           tags [NUM_LINES];
   logic [31:0]             data [NUM_LINES][WORDS_PER_LINE];
   logic [ADDR_WIDTH-OW-1:0] line;
   logic [WW-1:0]           cnt;
   logic                    flush_pending;
   logic [IW-1:0]           idx;
   logic [IW-1:0]           ridx;
   logic [WW-1:0]           word;
   logic [TW-1:0]           tag;
   logic                    hit;
   logic                    start;
   logic                    fill;
   logic                    done;
   logic                    unused_ok;
   assign idx       = cpu_addr[OW +: IW];
   assign word      = cpu_addr[2 +: WW];
   assign tag       = cpu_addr[ADDR_WIDTH-1 -: TW];
   assign ridx      = line[IW-1:0];
   assign unused_ok = ^cpu_addr[1:0];
   // flush in IDLE suppresses both the hit and any refill start
   assign hit       = state == IDLE && cpu_req_valid && !flush && valid[idx] && tags[idx] == tag;
   assign start     = state == IDLE && cpu_req_valid && !flush && !hit;
   assign fill      = state == WAIT && mem_resp_valid;
   assign done      = fill && cnt == WW'(WORDS_PER_LINE - 1);
   assign cpu_ready = hit;
   assign cpu_rdata = hit ? data[idx][word] : 32'h0;
   always_ff @(posedge clk) begin
      if (fill) begin
         data[ridx][cnt] <= mem_resp_data;
         if (done) tags[ridx] <= line[ADDR_WIDTH-OW-1 -: TW];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         valid         <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         cnt           <= '0;
         flush_pending <= 1'b0;
         line          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) valid <= '0;
               else if (start) begin
                  valid[idx]    <= 1'b0;
                  line          <= cpu_addr[ADDR_WIDTH-1:OW];
                  cnt           <= '0;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {cpu_addr[ADDR_WIDTH-1:OW], OW'(0)};
                  state         <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (done) begin
                  valid[ridx]   <= !flush_pending;
                  flush_pending <= 1'b0;
                  state         <= IDLE;
               end else if (fill) begin
                  cnt           <= cnt + 1'b1;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {line, cnt + 1'b1, 2'b00};
                  state         <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
         // a flush during refill also blocks validation of the line being filled
         if (flush && state != IDLE) begin
            valid         <= '0;
            flush_pending <= !done;
         end
      end
   end
`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else begin
         if (hit && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
         if (start && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_rv32i_icache.sv
// tb_rv32i_icache: directed checks of hits, refills, conflicts, backpressure, flush and reset for rv32i_icache.
module tb_rv32i_icache;
   logic        clk = 0;
   logic        rst = 1;
   logic        cpu_req_valid = 0;
   logic [31:0] cpu_addr = 0;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        flush = 0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid = 0;
   logic [31:0] mem_resp_data = 0;
`ifdef ICACHE_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
`endif
   int          checks = 0;
   int          failures = 0;
   logic        acc_q = 0;
   logic [31:0] addr_q = 0;
   logic [31:0] log_q [$];

   rv32i_icache dut (
      .clk(clk), .rst(rst), .cpu_req_valid(cpu_req_valid), .cpu_addr(cpu_addr),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef ICACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdl(input logic [31:0] a);
      case (a)
         32'h00:  return 32'h00500093;
         32'h04:  return 32'h00A00113;
         32'h08:  return 32'h002081B3;
         32'h0C:  return 32'h40110233;
         default: return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   // zero-wait memory: responds in the cycle after a request is accepted
   always @(negedge clk) begin
      acc_q  = mem_req_valid && mem_req_ready;
      addr_q = mem_req_addr;
      if (acc_q) log_q.push_back(mem_req_addr);
   end
   always @(posedge clk) begin
      #1;
      mem_resp_valid = acc_q;
      mem_resp_data  = acc_q ? mdl(addr_q) : 32'h0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_log(input logic [31:0] base, input int reps);
      chk("nreq", log_q.size(), 4 * reps);
      for (int i = 0; i < log_q.size() && i < 4 * reps; i++)
         chk("req_addr", log_q[i], base + 32'(4 * (i % 4)));
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      @(negedge clk);
      while (!cpu_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic fetch(input logic [31:0] a, input int lat);
      int n;
      log_q.delete();
      cpu_addr = a;
      cpu_req_valid = 1;
      wait_ready(n);
      chk("latency", n, lat);
      chk("rdata", cpu_rdata, mdl(a));
      if (lat == 0) chk("mreq_on_hit", mem_req_valid, 0);
      chk_log(a & ~32'hF, lat == 0 ? 0 : 1);
      @(posedge clk); #1;
      cpu_req_valid = 0;
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_ready", cpu_ready, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_mreq", mem_req_valid, 0);
      chk("rst_maddr", mem_req_addr, 0);
      @(posedge clk); #1;
      fetch(32'h00, 9);
      fetch(32'h04, 0);
      fetch(32'h08, 0);
      fetch(32'h0C, 0);
`ifdef ICACHE_STATS_EN
      chk("stat_hits", stat_hits, 4);
      chk("stat_misses", stat_misses, 1);
`endif
      fetch(32'h100, 9);
      fetch(32'h00, 9);
`ifdef ICACHE_STATS_EN
      chk("stat_misses3", stat_misses, 3);
`endif
      // backpressure on the first request of line 0x20
      log_q.delete();
      mem_req_ready = 0;
      cpu_addr = 32'h20;
      cpu_req_valid = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", mem_req_valid, 1);
         chk("bp_addr", mem_req_addr, 32'h20);
      end
      mem_req_ready = 1;
      wait_ready(n);
      chk("bp_ready", cpu_ready, 1);
      chk("bp_rdata", cpu_rdata, mdl(32'h20));
      chk_log(32'h20, 1);
      @(posedge clk); #1;
      cpu_req_valid = 0;
      // flush in IDLE wins over a hit and invalidates the line
      fetch(32'h04, 0);
      cpu_addr = 32'h04;
      cpu_req_valid = 1;
      flush = 1;
      @(negedge clk);
      chk("flush_idle_ready", cpu_ready, 0);
      @(posedge clk); #1;
      flush = 0;
      cpu_req_valid = 0;
      @(negedge clk);
      chk("flush_no_refill", mem_req_valid, 0);
      @(posedge clk); #1;
      fetch(32'h04, 9);
      // flush during WAIT of word 1: line completes unvalidated, then refetches
      log_q.delete();
      cpu_addr = 32'h40;
      cpu_req_valid = 1;
      repeat (4) begin @(posedge clk); #1; end
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      wait_ready(n);
      chk("flush_wait_lat", n, 13);
      chk("flush_wait_rdata", cpu_rdata, mdl(32'h40));
      chk_log(32'h40, 2);
      @(posedge clk); #1;
      cpu_req_valid = 0;
      // reset while in REQ; the late response must be ignored
      cpu_addr = 32'h80;
      cpu_req_valid = 1;
      @(posedge clk); #1;
      rst = 1;
      cpu_req_valid = 0;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rstmid_mreq", mem_req_valid, 0);
      chk("rstmid_ready", cpu_ready, 0);
      @(posedge clk); #1;
      fetch(32'h80, 9);
      fetch(32'h00, 9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
